// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register and the hazard unit.
// Tnew values count the cycles from ID until the instruction's result exists.
package id_ex_reg_pkg;

  localparam int unsigned TNEW_W = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

  localparam logic [31:0] BUBBLE_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/id_ex_reg_pipe_field.sv
// One pipeline field: synchronous reset to zero, synchronous clear to CLR_VAL,
// otherwise load. Priority is reset > clear > load.
module pipe_field_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= CLR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded state, bubble insertion
// on stall, residual Tnew tracking and a saturating bubble counter.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [DW-1:0] instr_D,
  input  logic [DW-1:0] pc8_D,
  input  logic [DW-1:0] rs_data_D,
  input  logic [DW-1:0] rt_data_D,
  input  logic [DW-1:0] ext_D,
  input  logic [AW-1:0] a3_D,
  input  logic [TW-1:0] tnew_D,
  output logic [DW-1:0] instr_E,
  output logic [DW-1:0] pc8_E,
  output logic [DW-1:0] rs_data_E,
  output logic [DW-1:0] rt_data_E,
  output logic [DW-1:0] ext_E,
  output logic [AW-1:0] a3_E,
  output logic [TW-1:0] tnew_E,
  output logic          valid_E,
  output logic          ready_E,
  output logic [31:0]   bubble_cnt
);

  logic [TW-1:0] tnew_next;
  logic          valid_q;
  logic [31:0]   bubble_q;

  // One stage elapses between ID and EX; an instruction with no writer has nothing pending.
  always_comb begin
    tnew_next = TW'(TNEW_NONE);
    if ((a3_D != '0) && (tnew_D != '0)) begin
      tnew_next = tnew_D - 1'b1;
    end
  end

  pipe_field_reg #(.W(DW), .CLR_VAL(DW'(NOP_INSTR))) u_instr (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(instr_D), .q(instr_E)
  );

  pipe_field_reg #(.W(DW)) u_pc8 (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(pc8_D), .q(pc8_E)
  );

  pipe_field_reg #(.W(DW)) u_rs_data (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(rs_data_D), .q(rs_data_E)
  );

  pipe_field_reg #(.W(DW)) u_rt_data (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(rt_data_D), .q(rt_data_E)
  );

  pipe_field_reg #(.W(DW)) u_ext (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(ext_D), .q(ext_E)
  );

  pipe_field_reg #(.W(AW)) u_a3 (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(a3_D), .q(a3_E)
  );

  pipe_field_reg #(.W(TW), .CLR_VAL(TW'(TNEW_NONE))) u_tnew (
    .clk(clk), .reset(reset), .clear(stall), .load(1'b1), .d(tnew_next), .q(tnew_E)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= ~stall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (stall && (bubble_q != BUBBLE_CNT_MAX)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign valid_E    = valid_q;
  assign bubble_cnt = bubble_q;
  assign ready_E    = valid_q & (a3_E != '0) & (tnew_E == '0);

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a per-edge behavioural model of the
// reset/stall/load rules, plus the directed scenarios for the register.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr_D = '0, pc8_D = '0, rs_data_D = '0, rt_data_D = '0, ext_D = '0;
  logic [4:0]  a3_D = '0;
  logic [1:0]  tnew_D = '0;
  logic [31:0] instr_E, pc8_E, rs_data_E, rt_data_E, ext_E;
  logic [4:0]  a3_E;
  logic [1:0]  tnew_E;
  logic        valid_E, ready_E;
  logic [31:0] bubble_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // model state
  logic [31:0] m_instr = '0, m_pc8 = '0, m_rs = '0, m_rt = '0, m_ext = '0;
  int          m_a3 = 0, m_tnew = 0;
  bit          m_valid = 0;
  longint      m_cnt = 0;

  id_ex_reg #(.DW(32), .AW(5), .TW(2)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .instr_D(instr_D), .pc8_D(pc8_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .ext_D(ext_D), .a3_D(a3_D), .tnew_D(tnew_D),
    .instr_E(instr_E), .pc8_E(pc8_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
    .ext_E(ext_E), .a3_E(a3_E), .tnew_E(tnew_E),
    .valid_E(valid_E), .ready_E(ready_E), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    bit m_ready;
    m_ready = m_valid && (m_a3 != 0) && (m_tnew == 0);
    check({ctx, ".instr"}, instr_E, m_instr);
    check({ctx, ".pc8"}, pc8_E, m_pc8);
    check({ctx, ".rs"}, rs_data_E, m_rs);
    check({ctx, ".rt"}, rt_data_E, m_rt);
    check({ctx, ".ext"}, ext_E, m_ext);
    check({ctx, ".a3"}, 32'(a3_E), 32'(m_a3));
    check({ctx, ".tnew"}, 32'(tnew_E), 32'(m_tnew));
    check({ctx, ".valid"}, 32'(valid_E), 32'(m_valid));
    check({ctx, ".ready"}, 32'(ready_E), 32'(m_ready));
    check({ctx, ".cnt"}, bubble_cnt, m_cnt[31:0]);
  endtask

  // Model of one clock edge: reset clears, stall makes a NOP bubble, else copy.
  task automatic model_edge(input bit r, input bit s);
    if (r) begin
      m_instr = 0; m_pc8 = 0; m_rs = 0; m_rt = 0; m_ext = 0;
      m_a3 = 0; m_tnew = 0; m_valid = 0; m_cnt = 0;
    end else if (s) begin
      m_instr = 0; m_pc8 = 0; m_rs = 0; m_rt = 0; m_ext = 0;
      m_a3 = 0; m_tnew = 0; m_valid = 0;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_instr = instr_D; m_pc8 = pc8_D; m_rs = rs_data_D; m_rt = rt_data_D; m_ext = ext_D;
      m_a3 = int'(a3_D);
      m_tnew = (a3_D == 0 || tnew_D == 0) ? 0 : int'(tnew_D) - 1;
      m_valid = 1;
    end
  endtask

  task automatic step(input bit r, input bit s, input string ctx);
    reset = r;
    stall = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    check_all(ctx);
  endtask

  task automatic rand_d();
    instr_D   = $urandom;
    pc8_D     = $urandom;
    rs_data_D = $urandom;
    rt_data_D = $urandom;
    ext_D     = $urandom;
    a3_D      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    tnew_D    = 2'($urandom_range(0, 3));
  endtask

  task automatic set_d(input logic [31:0] ins, input logic [31:0] pc8, input logic [31:0] ext,
                       input logic [4:0] a3, input logic [1:0] tn);
    instr_D = ins; pc8_D = pc8; ext_D = ext; a3_D = a3; tnew_D = tn;
    rs_data_D = $urandom; rt_data_D = $urandom;
  endtask

  initial begin
    rand_d();
    step(1, 0, "reset0");
    rand_d();
    step(1, 0, "reset1");

    set_d(32'h2528FFFF, 32'h0000_3008, 32'hFFFF_FFFF, 5'd8, 2'd1);
    step(0, 0, "addiu");
    check("addiu_instr_lit", instr_E, 32'h2528FFFF);
    check("addiu_ready_lit", 32'(ready_E), 32'd1);

    set_d(32'h8D25_0004, 32'h0000_300C, 32'h0000_0004, 5'd5, 2'd2);
    step(0, 0, "lw");
    check("lw_tnew_lit", 32'(tnew_E), 32'd1);
    check("lw_ready_lit", 32'(ready_E), 32'd0);

    set_d(32'h8C20_0004, 32'h0000_3010, 32'h0000_0004, 5'd0, 2'd2);
    step(0, 0, "lw_a3zero");

    set_d(32'h8D25_0008, 32'h0000_3014, 32'h0000_0008, 5'd5, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, "stall3");
      check("stall3_cnt_lit", bubble_cnt, 32'(i + 1));
    end
    step(0, 0, "release");
    check("release_tnew_lit", 32'(tnew_E), 32'd1);

    step(1, 1, "stall_reset");
    check("stall_reset_cnt_lit", bubble_cnt, 32'd0);

    // preload the counter near its ceiling
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    m_cnt = 64'hFFFF_FFFE;
    check("cnt_preload", bubble_cnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step(0, 1, "saturate");
      check("saturate_lit", bubble_cnt, 32'hFFFF_FFFF);
    end

    step(1, 0, "reset2");
    for (int i = 0; i < 400; i++) begin
      bit r, s;
      rand_d();
      r = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 3) == 0);
      step(r, s, "rand");
      rand_d();
      #1;
      check_all("rand_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage (ID) and the execute stage (EX) of the five-stage MIPS core.
- Captures the decoded instruction, PC+8, both GPR read values, the 32-bit extended immediate from the extender, the destination register number and the hazard Tnew.
- On a hazard stall, inserts a bubble (all-zero NOP) into EX.
- Keeps a saturating bubble counter for debug.

Parameters:
- DW, 32, datapath width of instr/pc8/rs/rt/ext fields
- AW, 5, register-address width
- TW, 2, Tnew field width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- stall  in  1  from hazard unit; 1 = insert bubble into EX this edge
- instr_D  in  DW  instruction in ID
- pc8_D  in  DW  PC+8 of ID instruction (link value)
- rs_data_D  in  DW  forwarded rs value
- rt_data_D  in  DW  forwarded rt value
- ext_D  in  DW  extender output (zero/sign/lui form)
- a3_D  in  AW  destination register of ID instruction (0 = none)
- tnew_D  in  TW  cycles from ID until result is producible
- instr_E  out  DW  registered instruction
- pc8_E  out  DW  registered PC+8
- rs_data_E  out  DW  registered rs value
- rt_data_E  out  DW  registered rt value
- ext_E  out  DW  registered immediate
- a3_E  out  AW  registered destination
- tnew_E  out  TW  residual Tnew in EX
- valid_E  out  1  1 = real instruction, 0 = bubble/reset
- ready_E  out  1  combinational: valid_E & (a3_E != 0) & (tnew_E == 0); EX result may be forwarded
- bubble_cnt  out  32  number of bubbles inserted since reset, saturating

Behaviour:
- Reset values: all outputs 0, including valid_E, ready_E and bubble_cnt. Reset has priority over everything.
- Priority per edge: reset > stall > load.
- Load (stall=0):
  - every *_E field <= its *_D field, valid_E <= 1.
  - tnew_E <= (tnew_D == 0) ? 0 : tnew_D - 1, a saturating decrement since one stage has elapsed.
  - If a3_D == 0, tnew_E <= 0 regardless of tnew_D; there is no writer.
- Stall (stall=1, reset=0):
  - instr_E, pc8_E, rs_data_E, rt_data_E, ext_E, a3_E, tnew_E <= 0; valid_E <= 0.
  - instr 32'h0 is sll $0,$0,0 (NOP).
  - bubble_cnt <= bubble_cnt + 1, holding at 32'hFFFF_FFFF (no wrap).
- Latency: exactly one cycle D→E. No combinational path from any *_D input to any *_E output; ready_E depends only on registered state.
- Back-to-back stalls: each stalled edge is a separate bubble and is counted separately.
- Stall and reset together: reset wins; bubble_cnt goes to 0, not 1.
- Reset deasserting mid-stream: first edge with reset=0 loads or bubbles normally; no extra idle cycle.
- ext_D is stored bit-exact; no re-extension in this block.
- Widths are fixed by parameters; no truncation except TW-bit Tnew arithmetic.

Decomposition:
- head.v gains:
  - `NOP_INSTR (32'h0000_0000)
  - `TNEW_W (2)
  - `TNEW_ALU (1), `TNEW_LOAD (2), `TNEW_NONE (0)
- The hazard unit and this block share these Tnew constants.
- One natural sub-module, pipe_field_reg: parameterised W-bit register with synchronous reset, synchronous clear and load. Instantiated once per data field.
- Tnew decrement, valid, ready and bubble counter logic stay in id_ex_reg.

Test Plan:
- Reset held 2 cycles with arbitrary D inputs → all *_E = 0, valid_E = 0, ready_E = 0, bubble_cnt = 0.
- addiu $8,$9,-1 (instr_D=32'h2528FFFF, ext_D=32'hFFFFFFFF, a3_D=8, tnew_D=1, pc8_D=32'h3008), stall=0 → next cycle:
  - instr_E = 32'h2528FFFF, ext_E = 32'hFFFFFFFF, pc8_E = 32'h3008, a3_E = 8
  - tnew_E = 0, valid_E = 1, ready_E = 1
- lw (a3_D=5, tnew_D=2) → tnew_E = 1, ready_E = 0. Same with a3_D=0 → tnew_E = 0, ready_E = 0.
- stall=1 for 3 consecutive cycles with a valid lw on the D inputs → each cycle all *_E = 0 and valid_E = 0. bubble_cnt goes 1, 2, 3. On release, the lw is loaded with tnew_E = 1.
- stall=1 and reset=1 on the same edge → bubble_cnt = 0 and all outputs 0.
- Force bubble_cnt to 32'hFFFF_FFFE, apply stall for 3 cycles → counter reads FFFF_FFFF, FFFF_FFFF, FFFF_FFFF.
